// File: rtl/ring_mon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ring_mon_pkg                                                    |
// | Desc   : Shared types, widths and status-bus bit positions for the ring  |
// |          phase monitor.                                                  |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package ring_mon_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    TRACK = 1'b1
  } ring_state_e;

  localparam int ERR_ONEHOT = 0;
  localparam int ERR_SEQ    = 1;
  localparam int ERR_STUCK  = 2;
  localparam int ERR_W      = 3;

  // Never returns 0, so a 1-entry range still gets a legal 1-bit vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : onehot_encoder                                                  |
// | Desc   : Combinational one-hot to binary encoder with legality flag.     |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module onehot_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     onehot_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_onehot_o
);

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign is_onehot_o = (onehot_i != '0) && ((onehot_i & (onehot_i - 1'b1)) == '0);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ring_phase_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ring_phase_monitor                                              |
// | Desc   : Decodes a one-hot ring token to a phase index, counts           |
// |          revolutions and flags non-one-hot, out-of-order or stalled      |
// |          tokens with sticky errors.                                      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N           = 4,
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    err_clear_i,
  input  logic [N-1:0]            ring_q_i,
  output logic [idx_width(N)-1:0] phase_idx_o,
  output logic                    phase_valid_o,
  output logic [CNT_W-1:0]        rev_count_o,
  output logic                    onehot_err_o,
  output logic                    seq_err_o,
  output logic                    stuck_err_o
);

  localparam int IDX_W = idx_width(N);
  localparam int SC_W  = idx_width(STUCK_LIMIT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [SC_W-1:0]  STUCK_MAX = SC_W'(STUCK_LIMIT);

  ring_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] rev_q, rev_d;
  logic [SC_W-1:0]  stuck_q, stuck_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] err_set;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_onehot;
  logic [IDX_W-1:0] next_idx;

  onehot_encoder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot_i    (ring_q_i),
    .idx_o       (enc_idx),
    .is_onehot_o (enc_onehot)
  );

  // N need not be a power of two, so the modulo step is explicit.
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    rev_d   = rev_q;
    stuck_d = stuck_q;
    prev_d  = prev_q;
    err_set = '0;

    if (en_i) begin
      prev_d = ring_q_i;
      if (ring_q_i == prev_q) begin
        if (stuck_q != STUCK_MAX) begin
          stuck_d = stuck_q + SC_W'(1);
        end
      end else begin
        stuck_d = '0;
      end
      if (stuck_d == STUCK_MAX) begin
        err_set[ERR_STUCK] = 1'b1;
      end

      if (!enc_onehot) begin
        err_set[ERR_ONEHOT] = 1'b1;
        valid_d             = 1'b0;
        state_d             = PRIME;
      end else begin
        case (state_q)
          PRIME: begin
            idx_d   = enc_idx;
            valid_d = 1'b1;
            state_d = TRACK;
          end
          TRACK: begin
            // A repeated index is a stall, which the stuck counter owns.
            if (enc_idx == next_idx) begin
              idx_d = enc_idx;
              if (idx_q == LAST_IDX) begin
                rev_d = rev_q + CNT_W'(1);
              end
            end else if (enc_idx != idx_q) begin
              idx_d            = enc_idx;
              err_set[ERR_SEQ] = 1'b1;
            end
          end
          default: state_d = PRIME;
        endcase
      end
    end

    // A fresh error in the same cycle as a clear keeps its flag set.
    err_d = (err_q & ~{ERR_W{err_clear_i}}) | err_set;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= PRIME;
      idx_q   <= '0;
      valid_q <= 1'b0;
      rev_q   <= '0;
      stuck_q <= '0;
      prev_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      rev_q   <= rev_d;
      stuck_q <= stuck_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
    end
  end

  assign phase_idx_o   = idx_q;
  assign phase_valid_o = valid_q;
  assign rev_count_o   = rev_q;
  assign onehot_err_o  = err_q[ERR_ONEHOT];
  assign seq_err_o     = err_q[ERR_SEQ];
  assign stuck_err_o   = err_q[ERR_STUCK];

endmodule
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_ring_phase_monitor                                           |
// | Desc   : Directed self-checking bench for ring_phase_monitor (N=4).      |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_ring_phase_monitor;

  typedef struct packed {
    logic [1:0] idx;
    logic       valid;
    logic [7:0] rev;
    logic       oh;
    logic       seq;
    logic       stuck;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  logic       clk;
  logic       reset_i;
  logic       en_i;
  logic       err_clear_i;
  logic [3:0] ring_q_i;
  logic [1:0] phase_idx_o;
  logic       phase_valid_o;
  logic [7:0] rev_count_o;
  logic       onehot_err_o;
  logic       seq_err_o;
  logic       stuck_err_o;
  obs_t       obs;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  ring_phase_monitor #(
    .N           (4),
    .CNT_W       (8),
    .STUCK_LIMIT (3)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .en_i          (en_i),
    .err_clear_i   (err_clear_i),
    .ring_q_i      (ring_q_i),
    .phase_idx_o   (phase_idx_o),
    .phase_valid_o (phase_valid_o),
    .rev_count_o   (rev_count_o),
    .onehot_err_o  (onehot_err_o),
    .seq_err_o     (seq_err_o),
    .stuck_err_o   (stuck_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {phase_idx_o, phase_valid_o, rev_count_o, onehot_err_o, seq_err_o, stuck_err_o};

  function automatic string fmt(input obs_t o);
    return $sformatf("idx=%0d valid=%0b rev=%0d oh=%0b seq=%0b stuck=%0b",
                     o.idx, o.valid, o.rev, o.oh, o.seq, o.stuck);
  endfunction

  // Drive one cycle, queue its expected outcome, compare just after the edge.
  task automatic step(input string tag, input logic rst, input logic en, input logic clr,
                      input logic [3:0] rq, input logic [1:0] e_idx, input logic e_v,
                      input logic [7:0] e_rev, input logic e_oh, input logic e_seq,
                      input logic e_stuck);
    exp_t e;
    exp_t got;
    reset_i     = rst;
    en_i        = en;
    err_clear_i = clr;
    ring_q_i    = rq;
    e.tag = tag;
    e.v   = {e_idx, e_v, e_rev, e_oh, e_seq, e_stuck};
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_cmp++;
    assert (obs === got.v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %s required %s", got.tag, fmt(obs), fmt(got.v));
    end
  endtask

  initial begin
    logic [7:0] rev;
    logic [3:0] rq;
    int         pp;
    reset_i     = 1'b1;
    en_i        = 1'b0;
    err_clear_i = 1'b0;
    ring_q_i    = 4'b0001;
    @(negedge clk);

    step("reset",        1, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0);
    step("prime0",       0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
    step("ph1",          0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0);
    step("ph2",          0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, 0);
    step("ph3",          0, 1, 0, 4'b1000, 3, 1, 0, 0, 0, 0);
    step("wrap_rev1",    0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 0);
    step("skip_seq",     0, 1, 0, 4'b0100, 2, 1, 1, 0, 1, 0);
    step("clr_no_en",    0, 0, 1, 4'b0100, 2, 1, 1, 0, 0, 0);
    step("two_hot",      0, 1, 0, 4'b0110, 2, 0, 1, 1, 0, 0);
    step("reprime3",     0, 1, 0, 4'b1000, 3, 1, 1, 1, 0, 0);
    step("clr_oh",       0, 0, 1, 4'b1000, 3, 1, 1, 0, 0, 0);
    step("wrap_rev2",    0, 1, 0, 4'b0001, 0, 1, 2, 0, 0, 0);
    step("hold1",        0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 0);
    step("hold2",        0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 0);
    step("hold3",        0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 0);
    step("hold4_stuck",  0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("en_off_%0d", i), 0, 0, 0, 4'b0110, 1, 1, 2, 0, 0, 1);
    end
    step("stuck_sat",    0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 1);
    step("clr_vs_zero",  0, 1, 1, 4'b0000, 1, 0, 2, 1, 0, 0);
    step("clr_alone",    0, 0, 1, 4'b0000, 1, 0, 2, 0, 0, 0);
    step("prime_revs",   0, 1, 0, 4'b0001, 0, 1, 2, 0, 0, 0);

    rev = 8'd2;
    for (int r = 0; r < 256; r++) begin
      for (int p = 1; p <= 4; p++) begin
        pp = p % 4;
        rq = 4'b0001 << pp;
        if (pp == 0) rev = rev + 8'd1;
        step($sformatf("rev_%0d_ph%0d", r, pp), 0, 1, 0, rq, 2'(pp), 1, rev, 0, 0, 0);
      end
    end
    step("after_revs",   0, 1, 0, 4'b0010, 1, 1, 2, 0, 0, 0);
    step("reset_mid",    1, 1, 1, 4'b0100, 0, 0, 0, 0, 0, 0);
    step("reprime_rst",  0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0);
    step("post_rst_ph1", 0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
